// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing single-outstanding imem requests into the fetch->decode register with one-entry skid
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        halted
);
  typedef enum logic [1:0] {REQ, WAIT, HALT} state_t;
  state_t      state_q;
  logic [31:0] pc_q, out_pc_q, out_inst_q, skid_pc_q, skid_inst_q;
  logic        out_valid_q, skid_valid_q, drop_q;
  logic [31:0] pc_inc_d;
  logic        direct_d;
  assign pc_inc_d  = pc_q + 32'd4;
  assign direct_d  = !stall || !out_valid_q;
  assign imem_req  = !rst && state_q == REQ;
  assign imem_addr = pc_q;
  assign halted    = state_q == HALT;
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_inst  = out_inst_q;
  // fetch FSM: halt beats redirect beats delivery; a WAIT with full skid has nothing in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      out_valid_q  <= 1'b0;
      out_pc_q     <= 32'd0;
      out_inst_q   <= NOP_INST;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'd0;
      skid_inst_q  <= NOP_INST;
      drop_q       <= 1'b0;
    end else if (halt || state_q == HALT) begin
      state_q      <= HALT;
      out_valid_q  <= 1'b0;
      out_pc_q     <= 32'd0;
      out_inst_q   <= NOP_INST;
      skid_valid_q <= 1'b0;
      drop_q       <= 1'b0;
    end else if (redirect) begin
      pc_q         <= redirect_pc & ~32'd3;
      out_valid_q  <= 1'b0;
      out_pc_q     <= 32'd0;
      out_inst_q   <= NOP_INST;
      skid_valid_q <= 1'b0;
      if (state_q == REQ) begin
        state_q <= imem_gnt ? WAIT : REQ;
        drop_q  <= imem_gnt;
      end else if (skid_valid_q || imem_rvalid) begin
        state_q <= REQ;
        drop_q  <= 1'b0;
      end else begin
        drop_q  <= 1'b1;
      end
    end else begin
      if (!stall) begin
        out_valid_q <= 1'b0;
        out_pc_q    <= 32'd0;
        out_inst_q  <= NOP_INST;
      end
      if (state_q == REQ) begin
        if (imem_gnt) state_q <= WAIT;
      end else if (skid_valid_q) begin
        if (!stall) begin
          out_valid_q  <= 1'b1;
          out_pc_q     <= skid_pc_q;
          out_inst_q   <= skid_inst_q;
          skid_valid_q <= 1'b0;
          state_q      <= REQ;
        end
      end else if (imem_rvalid) begin
        state_q <= REQ;
        if (drop_q) begin
          drop_q <= 1'b0;
        end else begin
          pc_q <= pc_inc_d;
          if (direct_d) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= pc_q;
            out_inst_q  <= imem_rdata;
          end else begin
            skid_valid_q <= 1'b1;
            skid_pc_q    <= pc_q;
            skid_inst_q  <= imem_rdata;
            state_q      <= WAIT;
          end
        end
      end
    end
  end
endmodule
